// File: rtl/nvm_arbiter.sv
// Round-robin arbiter sharing one single-port NVM array between instruction fetch and load/store,
// with a fixed programming lock after each write. Define NVM_WR_PROTECT_EN to reject writes below PROT_LIMIT.
module nvm_arbiter #(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int          WRITE_CYCLES = 4,
    parameter int unsigned PROT_LIMIT   = 'h100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_wdone,
    output logic                  ls_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic                  busy
);

    localparam logic [7:0]            ProgInit    = 8'(WRITE_CYCLES - 1);
    localparam bit                    SingleCycle = (WRITE_CYCLES == 1);
    localparam logic [ADDR_WIDTH-1:0] ProtLimit   = ADDR_WIDTH'(PROT_LIMIT);
`ifdef NVM_WR_PROTECT_EN
    localparam bit                    ProtEn      = 1'b1;
`else
    localparam bit                    ProtEn      = 1'b0;
`endif

    typedef enum logic {
        IDLE,
        PROG
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  prefLs_q, prefLs_d;
    logic [ADDR_WIDTH-1:0] lastAddr_q;
    logic                  ifRvalid_q, lsRvalid_q;
    logic [DATA_WIDTH-1:0] ifRdata_q, lsRdata_q;
    logic                  wdone_q, wdone_d;
    logic                  err_q;
    logic                  lsWrite, writeBlocked, doWrite;

    // prefLs_q set means load/store wins the next tie because fetch was granted last.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prefLs_d     = prefLs_q;
        wdone_d      = 1'b0;
        if_gnt       = 1'b0;
        ls_gnt       = 1'b0;
        lsWrite      = 1'b0;
        writeBlocked = 1'b0;
        doWrite      = 1'b0;

        if (!rst && state_q == IDLE) begin
            if (if_req && (!ls_req || !prefLs_q)) begin
                if_gnt = 1'b1;
            end else if (ls_req) begin
                ls_gnt = 1'b1;
            end
        end

        lsWrite      = ls_gnt & ls_we;
        writeBlocked = lsWrite & ProtEn & (ls_addr < ProtLimit);
        doWrite      = lsWrite & ~writeBlocked;

        if (if_gnt) begin
            prefLs_d = 1'b1;
        end else if (ls_gnt) begin
            prefLs_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (doWrite) begin
                    if (SingleCycle) begin
                        wdone_d = 1'b1;
                    end else begin
                        state_d = PROG;
                        cnt_d   = ProgInit;
                    end
                end
            end
            PROG: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = IDLE;
                    wdone_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        mem_we   = doWrite;
        mem_wd   = doWrite ? ls_wdata : '0;
        mem_addr = if_gnt ? if_addr : (ls_gnt ? ls_addr : lastAddr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prefLs_q   <= 1'b0;
            lastAddr_q <= '0;
            ifRvalid_q <= 1'b0;
            lsRvalid_q <= 1'b0;
            ifRdata_q  <= '0;
            lsRdata_q  <= '0;
            wdone_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prefLs_q   <= prefLs_d;
            lastAddr_q <= mem_addr;
            ifRvalid_q <= if_gnt;
            lsRvalid_q <= ls_gnt & ~ls_we;
            wdone_q    <= wdone_d;
            err_q      <= writeBlocked;
            if (if_gnt) begin
                ifRdata_q <= mem_rd;
            end
            if (ls_gnt && !ls_we) begin
                lsRdata_q <= mem_rd;
            end
        end
    end

    assign if_rvalid = ifRvalid_q;
    assign if_rdata  = ifRdata_q;
    assign ls_rvalid = lsRvalid_q;
    assign ls_rdata  = lsRdata_q;
    assign ls_wdone  = wdone_q;
    assign ls_err    = err_q;
    assign busy      = (state_q == PROG);

endmodule

// File: tb/tb_nvm_arbiter.sv
// Self-checking bench for nvm_arbiter: directed scenarios plus a randomized run against a
// cycle-count based model of arbitration, read latency and programming lock.
module tb_nvm_arbiter;

    localparam int          WC = 4;
    localparam logic [31:0] PL = 32'h100;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_wdone;
    logic        ls_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        busy;

    int testsRun;
    int testsFailed;

    // Behavioural NVM: unwritten words read as 0x90 + address.
    logic [31:0] memArr  [0:1023];
    bit          written [0:1023];

    nvm_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .WRITE_CYCLES(WC),
        .PROT_LIMIT  ('h100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_gnt   (ls_gnt),
        .ls_rvalid(ls_rvalid),
        .ls_rdata (ls_rdata),
        .ls_wdone (ls_wdone),
        .ls_err   (ls_err),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = written[mem_addr[9:0]] ? memArr[mem_addr[9:0]] : 32'h90 + 32'(mem_addr[9:0]);

    always @(posedge clk) begin
        if (mem_we) begin
            memArr[mem_addr[9:0]]  <= mem_wd;
            written[mem_addr[9:0]] <= 1'b1;
        end
    end

    task automatic applyReset();
        rst    = 1'b1;
        if_req = 1'b0;
        ls_req = 1'b0;
        ls_we  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        if_req   = 1'b1;
        ls_req   = 1'b1;
        ls_we    = 1'b0;
        if_addr  = 32'h44;
        ls_addr  = 32'h55;
        ls_wdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            testsRun++;
            if ({if_gnt, ls_gnt} !== 2'b00) begin
                testsFailed++;
                $display("[TB] FAIL reset_gnt: got %b expected 00", {if_gnt, ls_gnt});
            end
            @(negedge clk);
        end
        testsRun++;
        if ({if_rvalid, if_rdata, ls_rvalid, ls_rdata, ls_wdone, ls_err, mem_we, mem_addr, mem_wd, busy} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {if_rvalid, if_rdata, ls_rvalid, ls_rdata, ls_wdone, ls_err, mem_we, mem_addr, mem_wd, busy});
        end
        rst = 1'b0;
        #1;
        testsRun++;
        if ({if_gnt, ls_gnt} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL first_gnt: got %b expected 10", {if_gnt, ls_gnt});
        end
        ls_req = 1'b0;
        @(negedge clk);
        if_req = 1'b0;
        testsRun++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'hD4}) begin
            testsFailed++;
            $display("[TB] FAIL first_read: got %h expected 1_000000d4", {if_rvalid, if_rdata});
        end
    endtask

    task automatic test_fetch_stream();
        logic [31:0] expData;
        applyReset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                if_req  = 1'b1;
                if_addr = 32'h10 + 32'(i);
            end else begin
                if_req = 1'b0;
            end
            #1;
            testsRun++;
            if (if_gnt !== (i < 3)) begin
                testsFailed++;
                $display("[TB] FAIL stream_gnt[%0d]: got %b expected %b", i, if_gnt, (i < 3));
            end
            testsRun++;
            if (if_rvalid !== (i >= 1 && i <= 3)) begin
                testsFailed++;
                $display("[TB] FAIL stream_rvalid[%0d]: got %b expected %b", i, if_rvalid, (i >= 1 && i <= 3));
            end
            if (i >= 1) begin
                expData = 32'hA0 + 32'((i <= 3) ? i - 1 : 2);
                testsRun++;
                if (if_rdata !== expData) begin
                    testsFailed++;
                    $display("[TB] FAIL stream_rdata[%0d]: got %h expected %h", i, if_rdata, expData);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_contention();
        logic expIf, expLs;
        applyReset();
        if_req  = 1'b1;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        if_addr = 32'h30;
        ls_addr = 32'h20;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                if_req = 1'b0;
                ls_req = 1'b0;
            end
            #1;
            expIf = (i < 4) && (i % 2 == 0);
            expLs = (i < 4) && (i % 2 == 1);
            testsRun++;
            if ({if_gnt, ls_gnt} !== {expIf, expLs}) begin
                testsFailed++;
                $display("[TB] FAIL contention_gnt[%0d]: got %b expected %b", i, {if_gnt, ls_gnt}, {expIf, expLs});
            end
            if (i > 0) begin
                testsRun++;
                if ({if_rvalid, ls_rvalid} !== {(i % 2 == 1), (i % 2 == 0)}) begin
                    testsFailed++;
                    $display("[TB] FAIL contention_rvalid[%0d]: got %b expected %b", i,
                             {if_rvalid, ls_rvalid}, {(i % 2 == 1), (i % 2 == 0)});
                end
            end
            if (i == 4) begin
                testsRun++;
                if ({if_rdata, ls_rdata} !== {32'hC0, 32'hB0}) begin
                    testsFailed++;
                    $display("[TB] FAIL contention_rdata: got %h expected 000000c0_000000b0", {if_rdata, ls_rdata});
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write_lock();
        logic expIf, expLs, expBusy, expWe, expWdone;
        applyReset();
        if_req   = 1'b1;
        if_addr  = 32'h10;
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h200;
        ls_wdata = 32'hDEADBEEF;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) ls_req = 1'b0;
            if (c == 6) begin
                if_req  = 1'b0;
                ls_req  = 1'b1;
                ls_we   = 1'b0;
                ls_addr = 32'h200;
            end
            if (c == 7) ls_req = 1'b0;
            #1;
            expIf    = (c == 0) || (c == 5);
            expLs    = (c == 1) || (c == 6);
            expBusy  = (c >= 2) && (c <= 4);
            expWe    = (c == 1);
            expWdone = (c == 5);
            testsRun++;
            if ({if_gnt, ls_gnt, busy, mem_we, ls_wdone} !== {expIf, expLs, expBusy, expWe, expWdone}) begin
                testsFailed++;
                $display("[TB] FAIL wlock_ctrl[%0d] (gnt_if gnt_ls busy we wdone): got %b expected %b", c,
                         {if_gnt, ls_gnt, busy, mem_we, ls_wdone}, {expIf, expLs, expBusy, expWe, expWdone});
            end
            if (c == 1) begin
                testsRun++;
                if ({mem_addr, mem_wd} !== {32'h200, 32'hDEADBEEF}) begin
                    testsFailed++;
                    $display("[TB] FAIL wlock_wbus: got %h expected 00000200_deadbeef", {mem_addr, mem_wd});
                end
            end
            if (c >= 2 && c <= 4) begin
                testsRun++;
                if ({mem_addr, mem_wd} !== {32'h200, 32'h0}) begin
                    testsFailed++;
                    $display("[TB] FAIL wlock_hold[%0d]: got %h expected 00000200_00000000", c, {mem_addr, mem_wd});
                end
            end
            if (c == 7) begin
                testsRun++;
                if ({ls_rvalid, ls_rdata} !== {1'b1, 32'hDEADBEEF}) begin
                    testsFailed++;
                    $display("[TB] FAIL wlock_readback: got %h expected 1_deadbeef", {ls_rvalid, ls_rdata});
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_prog();
        applyReset();
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h201;
        ls_wdata = 32'h12345678;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) ls_req = 1'b0;
            if (c == 2) rst = 1'b1;
            if (c == 3) rst = 1'b0;
            if (c == 5) begin
                if_req  = 1'b1;
                if_addr = 32'h11;
            end
            if (c == 6) if_req = 1'b0;
            #1;
            if (c == 0) begin
                testsRun++;
                if (ls_gnt !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL midprog_gnt: got %b expected 1", ls_gnt);
                end
            end
            if (c >= 1 && c <= 2) begin
                testsRun++;
                if (busy !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL midprog_busy[%0d]: got %b expected 1", c, busy);
                end
            end
            if (c >= 3) begin
                testsRun++;
                if ({busy, ls_wdone} !== 2'b00) begin
                    testsFailed++;
                    $display("[TB] FAIL midprog_abandon[%0d]: got %b expected 00", c, {busy, ls_wdone});
                end
            end
            if (c == 5) begin
                testsRun++;
                if (if_gnt !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL midprog_resume: got %b expected 1", if_gnt);
                end
            end
            if (c == 6) begin
                testsRun++;
                if ({if_rvalid, if_rdata} !== {1'b1, 32'hA1}) begin
                    testsFailed++;
                    $display("[TB] FAIL midprog_read: got %h expected 1_000000a1", {if_rvalid, if_rdata});
                end
            end
            @(negedge clk);
        end
    endtask

`ifdef NVM_WR_PROTECT_EN
    task automatic test_write_protect();
        applyReset();
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h80;
        ls_wdata = 32'h55;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) ls_req = 1'b0;
            if (c == 2) begin
                ls_req = 1'b1;
                ls_we  = 1'b0;
            end
            if (c == 3) begin
                ls_we    = 1'b1;
                ls_addr  = 32'h300;
                ls_wdata = 32'h77;
            end
            if (c == 4) ls_req = 1'b0;
            #1;
            if (c == 0 || c == 3) begin
                testsRun++;
                if ({ls_gnt, mem_we} !== {1'b1, (c == 3)}) begin
                    testsFailed++;
                    $display("[TB] FAIL protect_we[%0d]: got %b expected %b", c, {ls_gnt, mem_we}, {1'b1, (c == 3)});
                end
            end
            if (c == 1) begin
                testsRun++;
                if ({ls_err, ls_wdone, busy} !== 3'b100) begin
                    testsFailed++;
                    $display("[TB] FAIL protect_err: got %b expected 100", {ls_err, ls_wdone, busy});
                end
            end
            if (c == 3) begin
                testsRun++;
                if ({ls_rvalid, ls_rdata} !== {1'b1, 32'h110}) begin
                    testsFailed++;
                    $display("[TB] FAIL protect_unchanged: got %h expected 1_00000110", {ls_rvalid, ls_rdata});
                end
            end
            if (c == 4) begin
                testsRun++;
                if ({busy, ls_err} !== 2'b10) begin
                    testsFailed++;
                    $display("[TB] FAIL protect_normal: got %b expected 10", {busy, ls_err});
                end
            end
            @(negedge clk);
        end
        repeat (WC) @(negedge clk);
    endtask
`endif

    // Model tracks time as cycle numbers: grants allowed once cyc reaches lockUntil,
    // responses due at recorded cycles, memory contents as a plain array.
    task automatic test_random();
        logic [31:0] refMem [0:511];
        logic [31:0] expIfData, expLsData, expWd;
        int          lockUntil, ifRvAt, lsRvAt, wdoneAt, errAt;
        bit          prefLs, ifGot, lsGot, allow, expIf, expLs, expWe, prot;
        for (int a = 0; a < 512; a++) refMem[a] = 32'h90 + 32'(a);
        applyReset();
        lockUntil = 0;
        ifRvAt    = -1;
        lsRvAt    = -1;
        wdoneAt   = -1;
        errAt     = -1;
        prefLs    = 1'b0;
        ifGot     = 1'b0;
        lsGot     = 1'b0;
        expIfData = 32'h0;
        expLsData = 32'h0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (ifGot) if_req = 1'b0;
            if (lsGot) ls_req = 1'b0;
            if (!if_req && $urandom_range(0, 2) != 0) begin
                if_req  = 1'b1;
                if_addr = 32'($urandom_range(0, 511));
            end
            if (!ls_req && $urandom_range(0, 2) != 0) begin
                ls_req   = 1'b1;
                ls_we    = ($urandom_range(0, 3) == 0);
                ls_addr  = 32'($urandom_range(0, 511));
                ls_wdata = $urandom;
            end
            #1;
            allow = (cyc >= lockUntil);
            expIf = allow && if_req && !(ls_req && prefLs);
            expLs = allow && ls_req && !expIf;
            prot  = 1'b0;
`ifdef NVM_WR_PROTECT_EN
            prot  = expLs && ls_we && (ls_addr < PL);
`endif
            expWe = expLs && ls_we && !prot;
            expWd = expWe ? ls_wdata : 32'h0;

            testsRun++;
            if ({if_gnt, ls_gnt} !== {expIf, expLs}) begin
                testsFailed++;
                $display("[TB] FAIL rand_gnt@%0d: got %b expected %b", cyc, {if_gnt, ls_gnt}, {expIf, expLs});
            end
            testsRun++;
            if ({if_rvalid, ls_rvalid, ls_wdone, ls_err, busy} !==
                {(cyc == ifRvAt), (cyc == lsRvAt), (cyc == wdoneAt), (cyc == errAt), (cyc < lockUntil)}) begin
                testsFailed++;
                $display("[TB] FAIL rand_status@%0d (ifrv lsrv wdone err busy): got %b expected %b", cyc,
                         {if_rvalid, ls_rvalid, ls_wdone, ls_err, busy},
                         {(cyc == ifRvAt), (cyc == lsRvAt), (cyc == wdoneAt), (cyc == errAt), (cyc < lockUntil)});
            end
            testsRun++;
            if ({if_rdata, ls_rdata} !== {expIfData, expLsData}) begin
                testsFailed++;
                $display("[TB] FAIL rand_rdata@%0d: got %h expected %h", cyc, {if_rdata, ls_rdata}, {expIfData, expLsData});
            end
            testsRun++;
            if ({mem_we, mem_wd} !== {expWe, expWd}) begin
                testsFailed++;
                $display("[TB] FAIL rand_wbus@%0d: got %h expected %h", cyc, {mem_we, mem_wd}, {expWe, expWd});
            end
            if (expIf || expLs) begin
                testsRun++;
                if (mem_addr !== (expIf ? if_addr : ls_addr)) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_addr@%0d: got %h expected %h", cyc, mem_addr, (expIf ? if_addr : ls_addr));
                end
            end

            if (expIf) begin
                ifRvAt    = cyc + 1;
                expIfData = refMem[if_addr[8:0]];
                prefLs    = 1'b1;
            end else if (expLs) begin
                prefLs = 1'b0;
                if (!ls_we) begin
                    lsRvAt    = cyc + 1;
                    expLsData = refMem[ls_addr[8:0]];
                end else if (prot) begin
                    errAt = cyc + 1;
                end else begin
                    refMem[ls_addr[8:0]] = ls_wdata;
                    lockUntil            = cyc + WC;
                    wdoneAt              = cyc + WC;
                end
            end
            ifGot = (if_gnt === 1'b1);
            lsGot = (ls_gnt === 1'b1);
            @(negedge clk);
        end
        if_req = 1'b0;
        ls_req = 1'b0;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        if_req      = 1'b0;
        if_addr     = 32'h0;
        ls_req      = 1'b0;
        ls_we       = 1'b0;
        ls_addr     = 32'h0;
        ls_wdata    = 32'h0;
        rst         = 1'b1;
        test_reset();
        test_fetch_stream();
        test_contention();
        test_write_lock();
        test_reset_mid_prog();
`ifdef NVM_WR_PROTECT_EN
        test_write_protect();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
